// File: rtl/escalonador_bordas.sv
// Two-channel rising-edge scheduler with round-robin grant of one shared resource.
// Ports: clk, rst (sync, active-low), entrada[1:0], ack, limpa_perdido -> grant, pendente, ocupado, perdido.
module escalonador_bordas #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] entrada,
    input  logic       ack,
    input  logic       limpa_perdido,
    output logic [1:0] grant,
    output logic [1:0] pendente,
    output logic       ocupado,
    output logic [1:0] perdido
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       estado;
    logic [1:0]       estado_prox;
    logic [1:0]       entrada_delay;
    logic [1:0]       borda;
    logic [1:0]       escolha;
    logic [1:0]       concede;
    logic [CNT_W-1:0] contador;
    logic             ultimo;
    logic             fim_janela;

    always_comb begin
        borda = entrada & ~entrada_delay;
    end

    // On a tie the channel that was not served last wins.
    always_comb begin
        escolha = 2'b00;
        unique case (1'b1)
            (pendente == 2'b11): escolha = ultimo ? 2'b01 : 2'b10;
            (pendente == 2'b01): escolha = 2'b01;
            (pendente == 2'b10): escolha = 2'b10;
            default:             escolha = 2'b00;
        endcase
    end

    // Only a decision taken in IDLE consumes a pending request.
    always_comb begin
        concede = (estado == IDLE) ? escolha : 2'b00;
    end

    always_comb begin
        fim_janela = ack || (contador == HOLD_MAX);
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            IDLE:    if (|pendente) estado_prox = GRANT;
            GRANT:   if (fim_janela) estado_prox = GAP;
            GAP:     estado_prox = IDLE;
            default: estado_prox = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            entrada_delay <= 2'b00;
            estado        <= IDLE;
            ocupado       <= 1'b0;
            pendente      <= 2'b00;
            perdido       <= 2'b00;
            grant         <= 2'b00;
            contador      <= '0;
            ultimo        <= 1'b1;
        end else begin
            entrada_delay <= entrada;
            estado        <= estado_prox;
            ocupado       <= (estado_prox != IDLE);
            // A fresh edge re-arms a request even on the cycle it is granted.
            pendente      <= borda | (pendente & ~concede);
            // A new flag in the same cycle as a clear takes precedence.
            perdido       <= (borda & pendente & ~concede)
                           | (perdido & {2{~limpa_perdido}});
            case (estado)
                IDLE: begin
                    if (|concede) begin
                        grant    <= concede;
                        contador <= CNT_ONE;
                        ultimo   <= concede[1];
                    end
                end
                GRANT: begin
                    if (fim_janela) begin
                        grant    <= 2'b00;
                        contador <= '0;
                    end else begin
                        contador <= contador + CNT_ONE;
                    end
                end
                default: begin
                    grant    <= 2'b00;
                    contador <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_escalonador_bordas.sv
// Scoreboard bench for escalonador_bordas: directed scenarios plus random traffic.
// Expected outputs come from a behavioural model and are checked one cycle later.
module tb_escalonador_bordas;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] entrada = 2'b00;
    logic       ack = 1'b0;
    logic       limpa_perdido = 1'b0;
    logic [1:0] grant;
    logic [1:0] pendente;
    logic       ocupado;
    logic [1:0] perdido;

    escalonador_bordas #(.HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .entrada(entrada),
        .ack(ack),
        .limpa_perdido(limpa_perdido),
        .grant(grant),
        .pendente(pendente),
        .ocupado(ocupado),
        .perdido(perdido)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] g;
        logic [1:0] p;
        logic [1:0] l;
        logic       o;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Model: who holds the resource, how long, and what is still waiting.
    int       owner = -1;
    int       held = 0;
    bit       in_gap = 1'b0;
    int       last_served = 1;
    bit [1:0] prev_in = 2'b00;
    bit [1:0] waiting = 2'b00;
    bit [1:0] lost = 2'b00;

    task automatic model(input logic [1:0] e, input logic a,
                         input logic lp, input logic r);
        bit [1:0] edges;
        int pick;
        exp_t x;
        if (!r) begin
            owner = -1; held = 0; in_gap = 1'b0; last_served = 1;
            prev_in = 2'b00; waiting = 2'b00; lost = 2'b00;
        end else begin
            edges = e & ~prev_in;
            prev_in = e;
            pick = -1;
            if (in_gap) begin
                in_gap = 1'b0;
            end else if (owner >= 0) begin
                if (a || held == HOLD) begin
                    owner = -1;
                    in_gap = 1'b1;
                end else begin
                    held++;
                end
            end else if (waiting != 2'b00) begin
                if (waiting == 2'b11) pick = 1 - last_served;
                else pick = waiting[1] ? 1 : 0;
                owner = pick; held = 1; last_served = pick;
            end
            for (int i = 0; i < 2; i++) begin
                if (edges[i] && waiting[i] && pick != i) lost[i] = 1'b1;
                else if (lp) lost[i] = 1'b0;
                waiting[i] = edges[i] || (waiting[i] && pick != i);
            end
        end
        x.g = (owner >= 0) ? 2'(1 << owner) : 2'b00;
        x.p = waiting;
        x.l = lost;
        x.o = (owner >= 0) || in_gap;
        q.push_back(x);
    endtask

    task automatic step(input logic [1:0] e, input logic a,
                        input logic lp, input logic r);
        @(negedge clk);
        entrada = e;
        ack = a;
        limpa_perdido = lp;
        rst = r;
        model(e, a, lp, r);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                total++;
                if (grant !== x.g) begin
                    bad++;
                    $display("FAIL grant t=%0t got=%b want=%b", $time, grant, x.g);
                end
                total++;
                if (pendente !== x.p) begin
                    bad++;
                    $display("FAIL pendente t=%0t got=%b want=%b", $time, pendente, x.p);
                end
                total++;
                if (perdido !== x.l) begin
                    bad++;
                    $display("FAIL perdido t=%0t got=%b want=%b", $time, perdido, x.l);
                end
                total++;
                if (ocupado !== x.o) begin
                    bad++;
                    $display("FAIL ocupado t=%0t got=%b want=%b", $time, ocupado, x.o);
                end
                total++;
                if (grant === 2'b11) begin
                    bad++;
                    $display("FAIL onehot t=%0t got=%b want=not 11", $time, grant);
                end
            end
        end
    end

    initial begin : stim
        logic [1:0] e;
        logic a, lp, r;
        // Reset with both inputs held high, then release.
        for (int i = 0; i < 3; i++) step(2'b11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(2'b11, 1'b0, 1'b0, 1'b1);
        idle_n(4);
        // Single request on channel 1, full window.
        step(2'b10, 1'b0, 1'b0, 1'b1);
        idle_n(9);
        // Two ties in a row.
        step(2'b11, 1'b0, 1'b0, 1'b1);
        idle_n(14);
        step(2'b11, 1'b0, 1'b0, 1'b1);
        idle_n(14);
        // Early release in the second grant cycle, ack while idle.
        step(2'b01, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b1, 1'b0, 1'b1);
        idle_n(3);
        for (int i = 0; i < 3; i++) step(2'b00, 1'b1, 1'b0, 1'b1);
        idle_n(2);
        // Overflow, clear, and set-wins-over-clear.
        step(2'b10, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 1'b1);
        step(2'b01, 1'b0, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        step(2'b01, 1'b0, 1'b1, 1'b1);
        idle_n(14);
        step(2'b00, 1'b0, 1'b1, 1'b1);
        idle_n(2);
        // Level held for 20 cycles gives one request only.
        for (int i = 0; i < 20; i++) step(2'b01, 1'b0, 1'b0, 1'b1);
        idle_n(3);
        step(2'b01, 1'b0, 1'b0, 1'b1);
        idle_n(8);
        // Random traffic with occasional ack, clear and reset.
        e = 2'b00;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) e = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0);
            lp = ($urandom_range(0, 15) == 0);
            r  = !($urandom_range(0, 199) == 0);
            step(e, a, lp, r);
        end
        idle_n(2);
        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/escalonador_bordas.md
Name: escalonador_bordas

Overview:
Two-channel event scheduler. It detects rising edges on a 2-bit raw input and queues one pending request per channel. It then grants a single shared downstream resource to one channel at a time, using a round-robin arbiter, a fixed maximum grant window and an early-release acknowledge. It sits between the raw event inputs and the shared consumer; the consumer sees only a one-hot grant and returns ack.

Parameters:
HOLD_CYCLES, 4, maximum grant length in clock cycles; legal range 1..255.
CNT_W, 8, width of the internal grant counter; must hold HOLD_CYCLES.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous reset, active-low; sampled on posedge clk.
entrada  input  2  raw event levels, one bit per channel; assumed synchronous to clk.
ack  input  1  consumer done; ends the current grant early.
limpa_perdido  input  1  clears the perdido flags.
grant  output  2  one-hot grant, registered; 00 when idle.
pendente  output  2  queued request per channel, registered.
ocupado  output  1  high whenever the FSM is not in IDLE.
perdido  output  2  sticky per-channel overflow flag: an edge arrived while a request was already queued.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst=0 at posedge clears everything: internal entrada_delay=00, pendente=00, grant=00, perdido=00, ocupado=0, FSM=IDLE, counter=0, round-robin pointer ultimo=1 (so channel 0 wins the first tie).
  - Reset mid-grant aborts the grant; grant=00 after that edge.
- Edge detection:
  - borda = entrada & ~entrada_delay (combinational); entrada_delay <= entrada every non-reset edge.
  - Because entrada_delay resets to 00, an input held high across reset release produces an edge on the first non-reset edge.
- Pending and overflow, per channel i:
  - pendente[i] set at the edge where borda[i]=1.
  - pendente[i] cleared at the edge where channel i is granted (IDLE->GRANT).
  - If borda[i] coincides with that grant, pendente[i] remains set as a new request, and no overflow is flagged.
  - If borda[i]=1 while pendente[i]=1 and i is not being granted, perdido[i] is set.
  - limpa_perdido=1 clears perdido; a set in the same cycle wins.
- FSM states: IDLE, GRANT, GAP.
  - IDLE: if registered pendente != 00, go to GRANT and drive grant to the chosen one-hot.
    - Only one bit set: that channel.
    - Both set: the channel other than ultimo.
    - On grant: ultimo <= chosen channel; counter <= 1.
    - Requests arriving in the current cycle are not considered until the next cycle.
  - GRANT: grant held constant.
    - If ack=1 or counter==HOLD_CYCLES: go to GAP with grant=00.
    - Otherwise counter increments.
    - Without ack, grant is high for exactly HOLD_CYCLES cycles; ack in the first grant cycle gives a 1-cycle grant.
  - GAP: exactly one cycle with grant=00, then IDLE.
    - Two grants are therefore never back-to-back: minimum 2 dead cycles, GAP plus IDLE decision.
  - ack is ignored in IDLE and GAP.
- Latency: borda at posedge k -> pendente visible after k -> grant visible after k+1, when the FSM is in IDLE.
- ocupado = (FSM != IDLE), registered with the state.
- Invariant: grant is never 11.

Test Plan:
- Reset release with entrada=11 held, HOLD_CYCLES=4: during rst=0, all outputs 0 -> first edge after release gives pendente=11 -> next edge grant=01, pendente=10 -> after 4 cycles plus GAP, grant=10.
- Single 0->1 on entrada[1], ack=0, HOLD_CYCLES=4: grant=10 for exactly 4 cycles, then 1 GAP cycle with grant=00; ocupado high for 5 cycles; pendente=00 afterwards.
- Both channels requested together twice in a row: grant order is 01, 10; the second tie is again 01, 10 because ultimo=1 after channel 1.
- Early release: grant=01 active, ack=1 in the 2nd grant cycle: grant drops to 00 after that edge, counter never reaches 4, GAP follows; ack=1 while IDLE has no effect.
- Overflow: channel 1 granted, channel 0 pending, a second rising edge on entrada[0] gives perdido=01; a pulse on limpa_perdido gives perdido=00; an edge and a clear in the same cycle give perdido=01.
- entrada[0] held high for 20 cycles: exactly one request and one grant; no further requests until entrada[0] falls and rises again.
